pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//  Sequences the 50/200 MHz PLL: pulses its reset, waits for lock with timeout and retries,
//  qualifies lock as stable, then releases the downstream system reset and raises ready.
//  Sits beside the PLL instance at the top level. Runs on the free-running reference clock,
//  so it operates before any PLL output exists.
// PARAMETERS
//  RST_PULSE_CYC    16     cycles pll_rst is held high per attempt (>=2)
//  LOCK_TIMEOUT_CYC 50000  cycles to wait for synced lock before retrying (>=2)
//  LOCK_STABLE_CYC  1024   consecutive synced-lock cycles required before release (>=2)
//  MAX_RETRIES      3      retries after the first attempt before FAIL (1..15)
//  CNT_W            16     shared cycle-counter width; must hold the largest *_CYC value
// PORTS
//  refclk      in   1  reference clock (50 MHz), the only clock
//  rst         in   1  synchronous, active-high reset
//  pll_locked  in   1  PLL locked, asynchronous to refclk
//  relock_req  in   1  single-cycle request to restart the sequence
//  pll_rst     out  1  reset to PLL, active-high
//  sys_rst     out  1  downstream system reset, active-high
//  ready       out  1  PLL locked and stable; system running
//  fail        out  1  sticky: retries exhausted or lock lost
//  retry_cnt   out  4  failed attempts in the current sequence
// BEHAVIOUR
//  - pll_locked passes through a 2-flop synchronizer to locked_s (2-cycle latency).
//    The FSM uses only locked_s.
//  - All outputs are registered and decoded from next-state, so they change on the same edge
//    as the state.
//  - Reset (rst=1 on an edge): state=S_RST, cnt=0, retry_cnt=0, pll_rst=1, sys_rst=1,
//    ready=0, fail=0, sync flops=0. rst mid-sequence aborts immediately to these values.
//  - S_RST (pll_rst=1, sys_rst=1): cnt++.
//    At cnt==RST_PULSE_CYC-1 -> S_WAIT with cnt=0.
//  - S_WAIT (pll_rst=0, sys_rst=1):
//    - locked_s=1 -> S_STABLE with cnt=0.
//    - Else at cnt==LOCK_TIMEOUT_CYC-1, treat as a failed attempt (see below).
//  - S_STABLE (sys_rst=1): cnt++ while locked_s=1.
//    - locked_s=0 -> failed attempt.
//    - cnt==LOCK_STABLE_CYC-1 with locked_s=1 -> S_RUN.
//  - Failed attempt:
//    - retry_cnt==MAX_RETRIES -> S_FAIL.
//    - Else retry_cnt++ and go to S_RST with cnt=0.
//  - S_RUN (pll_rst=0, sys_rst=0, ready=1): cnt is held at 0.
//    - locked_s=0 -> lock-loss handling; see CONFIGURATION.
//  - S_FAIL (pll_rst=1, sys_rst=1, ready=0, fail=1): stays until rst or relock_req.
//  - relock_req=1 in any state except S_RST: -> S_RST, cnt=0, retry_cnt=0, fail=0.
//    In S_RST it is ignored.
//  - Simultaneous events: rst overrides relock_req, which overrides lock events and timeout.
//  - Counter never wraps: every compare is an equality at *_CYC-1 and cnt clears on every
//    state change.
//  - ready and sys_rst are always complementary. fail=1 implies ready=0.
// CONFIGURATION
//  - PLL_SEQ_AUTO_RELOCK_EN defined: locked_s=0 in S_RUN -> S_RST.
//    - retry_cnt=0, sys_rst=1 and ready=0 on the same edge.
//    - A saturating 8-bit output lock_loss_cnt[7:0] (reset 0) increments on each such event.
//  - Not defined: locked_s=0 in S_RUN -> S_FAIL (fail=1, sys_rst=1, pll_rst=1).
//    - The lock_loss_cnt port does not exist.
// TESTING
//  Bench parameters: RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRIES=2.
//  1. Release rst with pll_locked=1 constant -> pll_rst high 4 cycles; locked_s is seen 2 cycles
//     after sampling; ready=1/sys_rst=0 exactly 8 cycles after S_STABLE entry; retry_cnt=0.
//  2. pll_locked=0 constant -> three 4-cycle pll_rst pulses spaced by 20-cycle waits;
//     retry_cnt steps 1,2; then fail=1, pll_rst=1, sys_rst=1, ready=0.
//  3. pll_locked drops for 1 cycle 5 cycles into S_STABLE -> retry_cnt=1, new 4-cycle pll_rst
//     pulse; with lock restored, ready=1 after a full 8 stable cycles.
//  4. In S_RUN drop pll_locked -> macro on: ready=0 and pll_rst=1 two edges later,
//     lock_loss_cnt=1, ready returns. Macro off: fail=1, stays until relock_req.
//  5. relock_req pulsed in S_FAIL with pll_locked=1 -> fail=0, retry_cnt=0, full sequence to
//     ready=1. relock_req together with rst -> reset values only.
//  6. rst asserted mid S_WAIT and mid S_RUN -> next edge all outputs at reset values, cnt=0.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the reference clock: pulses pll_rst, waits for lock with retries,
// qualifies stable lock, then releases sys_rst. Optional macro PLL_SEQ_AUTO_RELOCK_EN.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 3,
    parameter int CNT_W            = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             attempt_fail;
    logic             sync_q, locked_s;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
    logic             loss_evt;
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        retry_nxt    = retry_cnt;
        attempt_fail = 1'b0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
        loss_evt     = 1'b0;
`endif
        if (relock_req && state != S_RST) begin
            state_nxt = S_RST;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                S_RST: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        attempt_fail = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        attempt_fail = 1'b1;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    cnt_nxt = '0;
                    if (!locked_s) begin
`ifdef PLL_SEQ_AUTO_RELOCK_EN
                        state_nxt = S_RST;
                        retry_nxt = '0;
                        loss_evt  = 1'b1;
`else
                        state_nxt = S_FAIL;
`endif
                    end
                end
                S_FAIL: cnt_nxt = '0;
                default: begin
                    state_nxt = S_RST;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // A failed attempt either retries with a fresh pll_rst pulse or gives up.
        if (attempt_fail) begin
            cnt_nxt = '0;
            if (retry_cnt == RETRY_MAX) begin
                state_nxt = S_FAIL;
            end else begin
                state_nxt = S_RST;
                retry_nxt = retry_cnt + 4'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_RST;
            cnt       <= '0;
            retry_cnt <= '0;
            sync_q    <= 1'b0;
            locked_s  <= 1'b0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            lock_loss_cnt <= '0;
`endif
        end else begin
            sync_q    <= pll_locked;
            locked_s  <= sync_q;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            // Outputs decode next-state so they move on the same edge as the state.
            pll_rst   <= (state_nxt == S_RST) || (state_nxt == S_FAIL);
            sys_rst   <= (state_nxt != S_RUN);
            ready     <= (state_nxt == S_RUN);
            fail      <= (state_nxt == S_FAIL);
`ifdef PLL_SEQ_AUTO_RELOCK_EN
            if (loss_evt && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
`endif
        end
    end

endmodule
